// File: rtl/ibex_clic_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ibex_clic_pkg
// Brief    : Shared widths and per-source configuration type for the CLIC arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ibex_clic_pkg;

  localparam int CLIC_ID_W   = 12;
  localparam int CLIC_PRIO_W = 8;
  localparam int CLIC_CFG_W  = CLIC_PRIO_W + 2;

  typedef struct packed {
    logic                   enable;
    logic                   edge_trig;
    logic [CLIC_PRIO_W-1:0] prio;
  } clic_cfg_t;

endpackage
`default_nettype wire

// File: rtl/ibex_clic_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : ibex_clic_arbiter_if
// Brief     : Request/claim link between the CLIC arbiter and the fast-IRQ wrapper.
// Revision  : 1.0 - initial release
// ============================================================================
interface ibex_clic_arbiter_if;

  logic                                  clic_irq_o;
  logic [ibex_clic_pkg::CLIC_ID_W-1:0]   clic_irq_id_o;
  logic [ibex_clic_pkg::CLIC_PRIO_W-1:0] clic_irq_priority_o;
  logic                                  claim_i;
  logic [ibex_clic_pkg::CLIC_ID_W-1:0]   claim_id_i;
  logic [ibex_clic_pkg::CLIC_PRIO_W-1:0] threshold_i;

  modport master (
    output clic_irq_o, clic_irq_id_o, clic_irq_priority_o,
    input  claim_i, claim_id_i, threshold_i
  );

  modport slave (
    input  clic_irq_o, clic_irq_id_o, clic_irq_priority_o,
    output claim_i, claim_id_i, threshold_i
  );

endinterface
`default_nettype wire

// File: rtl/ibex_clic_prio_tree.sv
`default_nettype none
// ============================================================================
// Module   : ibex_clic_prio_tree
// Brief    : Combinational binary max-tree over {eligible, prio, idx}; lower index wins ties.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_clic_prio_tree import ibex_clic_pkg::*; #(
  parameter  int NUM_SRC = 32,
  localparam int IDX_W   = $clog2(NUM_SRC)
) (
  input  wire logic [NUM_SRC-1:0]                  i_elig,
  input  wire logic [NUM_SRC-1:0][CLIC_PRIO_W-1:0] i_prio,
  output logic                                     o_vld,
  output logic [IDX_W-1:0]                         o_idx,
  output logic [CLIC_PRIO_W-1:0]                   o_prio
);

  localparam int c_nleaf = 1 << IDX_W;

  // Level 0 holds the (padded) leaves; each higher level halves the node count.
  for (genvar l = 0; l <= IDX_W; l++) begin : g_lvl
    localparam int c_n = c_nleaf >> l;
    logic                   w_vld  [c_n];
    logic [CLIC_PRIO_W-1:0] w_prio [c_n];
    logic [IDX_W-1:0]       w_idx  [c_n];

    if (l == 0) begin : g_leaf
      for (genvar j = 0; j < c_n; j++) begin : g_j
        if (j < NUM_SRC) begin : g_src
          assign w_vld[j]  = i_elig[j];
          assign w_prio[j] = i_prio[j];
        end else begin : g_pad
          assign w_vld[j]  = 1'b0;
          assign w_prio[j] = '0;
        end
        assign w_idx[j] = IDX_W'(j);
      end
    end else begin : g_node
      for (genvar j = 0; j < c_n; j++) begin : g_j
        logic w_take_r;
        // The right child only wins on strictly higher priority, so ties keep the lower index.
        assign w_take_r  = g_lvl[l-1].w_vld[2*j+1] &&
                           (!g_lvl[l-1].w_vld[2*j] ||
                            (g_lvl[l-1].w_prio[2*j+1] > g_lvl[l-1].w_prio[2*j]));
        assign w_vld[j]  = g_lvl[l-1].w_vld[2*j] | g_lvl[l-1].w_vld[2*j+1];
        assign w_prio[j] = w_take_r ? g_lvl[l-1].w_prio[2*j+1] : g_lvl[l-1].w_prio[2*j];
        assign w_idx[j]  = w_take_r ? g_lvl[l-1].w_idx[2*j+1]  : g_lvl[l-1].w_idx[2*j];
      end
    end
  end

  assign o_vld  = g_lvl[IDX_W].w_vld[0];
  assign o_idx  = g_lvl[IDX_W].w_idx[0];
  assign o_prio = g_lvl[IDX_W].w_prio[0];

endmodule
`default_nettype wire

// File: rtl/ibex_clic_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ibex_clic_arbiter
// Brief    : CLIC gateway: per-source config, edge/level pending, registered max-priority request.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_clic_arbiter import ibex_clic_pkg::*; #(
  parameter  int NUM_SRC = 32,
  localparam int IDX_W   = $clog2(NUM_SRC)
) (
  input  wire logic                  clk_i,
  input  wire logic                  rst_i,
  input  wire logic [NUM_SRC-1:0]    irq_src_i,
  input  wire logic                  cfg_we_i,
  input  wire logic [IDX_W-1:0]      cfg_idx_i,
  input  wire logic [CLIC_CFG_W-1:0] cfg_wdata_i,
  ibex_clic_arbiter_if.master        bus,
  output logic [NUM_SRC-1:0]         pending_o
);

  clic_cfg_t                           r_cfg [NUM_SRC];
  logic [NUM_SRC-1:0]                  r_prev;
  logic [NUM_SRC-1:0]                  r_pend;
  logic                                r_irq;
  logic [CLIC_ID_W-1:0]                r_id;
  logic [CLIC_PRIO_W-1:0]              r_prio;

  logic [NUM_SRC-1:0]                  w_elig;
  logic [NUM_SRC-1:0]                  w_claim;
  logic [NUM_SRC-1:0][CLIC_PRIO_W-1:0] w_prio;
  logic                                w_cfg_hit;
  logic                                w_win_vld;
  logic [IDX_W-1:0]                    w_win_idx;
  logic [CLIC_PRIO_W-1:0]              w_win_prio;

  assign w_cfg_hit = cfg_we_i && (32'(cfg_idx_i) < NUM_SRC);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_SRC; i++) r_cfg[i] <= '0;
    end else if (w_cfg_hit) begin
      r_cfg[cfg_idx_i] <= clic_cfg_t'(cfg_wdata_i);
    end
  end

  always_comb begin
    w_elig  = '0;
    w_claim = '0;
    w_prio  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_prio[i]  = r_cfg[i].prio;
      w_elig[i]  = r_pend[i] & r_cfg[i].enable & (r_cfg[i].prio > bus.threshold_i);
      w_claim[i] = bus.claim_i & (bus.claim_id_i == CLIC_ID_W'(i));
    end
  end

  // Edge sources: a fresh rising edge beats a simultaneous claim.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prev <= '0;
      r_pend <= '0;
    end else begin
      r_prev <= irq_src_i;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (r_cfg[i].edge_trig) begin
          r_pend[i] <= (irq_src_i[i] & ~r_prev[i]) | (r_pend[i] & ~w_claim[i]);
        end else begin
          r_pend[i] <= irq_src_i[i];
        end
      end
    end
  end

  ibex_clic_prio_tree #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_tree (
    .i_elig (w_elig),
    .i_prio (w_prio),
    .o_vld  (w_win_vld),
    .o_idx  (w_win_idx),
    .o_prio (w_win_prio)
  );

  // Id and priority keep their last winner while no source is eligible.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_irq  <= 1'b0;
      r_id   <= '0;
      r_prio <= '0;
    end else begin
      r_irq <= w_win_vld;
      if (w_win_vld) begin
        r_id   <= CLIC_ID_W'(w_win_idx);
        r_prio <= w_win_prio;
      end
    end
  end

  assign bus.clic_irq_o          = r_irq;
  assign bus.clic_irq_id_o       = r_id;
  assign bus.clic_irq_priority_o = r_prio;
  assign pending_o               = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_ibex_clic_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_clic_arbiter
// Brief    : Self-checking bench: directed scenarios plus random traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_clic_arbiter;

  localparam int NUM_SRC = 32;
  localparam int IDX_W   = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_SRC-1:0] irq_src;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic [9:0]         cfg_wdata;
  logic [NUM_SRC-1:0] pending;

  int total = 0;
  int bad   = 0;

  ibex_clic_arbiter_if bus();

  ibex_clic_arbiter #(.NUM_SRC(NUM_SRC)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .irq_src_i   (irq_src),
    .cfg_we_i    (cfg_we),
    .cfg_idx_i   (cfg_idx),
    .cfg_wdata_i (cfg_wdata),
    .bus         (bus),
    .pending_o   (pending)
  );

  always #5 clk = ~clk;

  // Reference model: per-source state kept as plain arrays, winner found by linear scan.
  bit m_en   [NUM_SRC];
  bit m_edge [NUM_SRC];
  int m_prio [NUM_SRC];
  bit m_pend [NUM_SRC];
  bit m_prev [NUM_SRC];
  bit m_irq;
  int m_id;
  int m_pr;

  function automatic int model_winner();
    int best = -1;
    int bp   = -1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (m_pend[i] && m_en[i] && (m_prio[i] > int'(bus.threshold_i)) && (m_prio[i] > bp)) begin
        best = i;
        bp   = m_prio[i];
      end
    end
    return best;
  endfunction

  function automatic logic [NUM_SRC-1:0] model_pend();
    logic [NUM_SRC-1:0] v;
    for (int i = 0; i < NUM_SRC; i++) v[i] = m_pend[i];
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        m_en[i] <= 0; m_edge[i] <= 0; m_prio[i] <= 0; m_pend[i] <= 0; m_prev[i] <= 0;
      end
      m_irq <= 0; m_id <= 0; m_pr <= 0;
    end else begin
      if (model_winner() >= 0) begin
        m_irq <= 1;
        m_id  <= model_winner();
        m_pr  <= m_prio[model_winner()];
      end else begin
        m_irq <= 0;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (m_edge[i])
          m_pend[i] <= (irq_src[i] && !m_prev[i]) ||
                       (m_pend[i] && !(bus.claim_i && int'(bus.claim_id_i) == i));
        else
          m_pend[i] <= irq_src[i];
        m_prev[i] <= irq_src[i];
      end
      if (cfg_we) begin
        m_en[cfg_idx]   <= cfg_wdata[9];
        m_edge[cfg_idx] <= cfg_wdata[8];
        m_prio[cfg_idx] <= int'(cfg_wdata[7:0]);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cfg_write(input int idx, input bit en, input bit edg, input int pr);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_idx   = idx[IDX_W-1:0];
    cfg_wdata = {en, edg, pr[7:0]};
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic claim(input int id);
    bus.claim_i    = 1'b1;
    bus.claim_id_i = id[11:0];
    step();
    bus.claim_i    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_src = '1;
    repeat (2) step();
    total++; if (bus.clic_irq_o !== 1'b0) begin bad++; $display("FAIL rst_irq: got %0h want 0", bus.clic_irq_o); end
    total++; if (bus.clic_irq_id_o !== 12'h0) begin bad++; $display("FAIL rst_id: got %0h want 0", bus.clic_irq_id_o); end
    total++; if (bus.clic_irq_priority_o !== 8'h0) begin bad++; $display("FAIL rst_prio: got %0h want 0", bus.clic_irq_priority_o); end
    total++; if (pending !== '0) begin bad++; $display("FAIL rst_pend: got %0h want 0", pending); end
    irq_src = '0;
    rst = 1'b0;
    step();
    total++; if (pending !== '0) begin bad++; $display("FAIL rst_release_pend: got %0h want 0", pending); end
  endtask

  task automatic test_edge_claim();
    cfg_write(5, 1, 1, 'h40);
    irq_src[5] = 1'b1;
    step(); irq_src[5] = 1'b0;
    total++; if (pending[5] !== 1'b1) begin bad++; $display("FAIL edge_pend: got %0h want 1", pending[5]); end
    total++; if (bus.clic_irq_o !== 1'b0) begin bad++; $display("FAIL edge_lat1: got %0h want 0", bus.clic_irq_o); end
    step();
    total++; if ({bus.clic_irq_o, bus.clic_irq_id_o, bus.clic_irq_priority_o} !== {1'b1, 12'd5, 8'h40})
      begin bad++; $display("FAIL edge_req: got irq=%0h id=%0d prio=%0h want 1/5/40", bus.clic_irq_o, bus.clic_irq_id_o, bus.clic_irq_priority_o); end
    repeat (3) step();
    total++; if (bus.clic_irq_o !== 1'b1) begin bad++; $display("FAIL edge_hold: got %0h want 1", bus.clic_irq_o); end
    claim(5);
    total++; if ({pending[5], bus.clic_irq_o} !== 2'b01) begin bad++; $display("FAIL claim_lat1: got pend=%0h irq=%0h want 0/1", pending[5], bus.clic_irq_o); end
    step();
    total++; if ({bus.clic_irq_o, bus.clic_irq_id_o, bus.clic_irq_priority_o} !== {1'b0, 12'd5, 8'h40})
      begin bad++; $display("FAIL claim_drop: got irq=%0h id=%0d prio=%0h want 0/5/40", bus.clic_irq_o, bus.clic_irq_id_o, bus.clic_irq_priority_o); end
  endtask

  task automatic test_tie();
    cfg_write(3, 1, 1, 'h20);
    cfg_write(9, 1, 1, 'h20);
    irq_src[3] = 1'b1; irq_src[9] = 1'b1;
    step(); irq_src = '0;
    step();
    total++; if ({bus.clic_irq_o, bus.clic_irq_id_o, bus.clic_irq_priority_o} !== {1'b1, 12'd3, 8'h20})
      begin bad++; $display("FAIL tie_low: got irq=%0h id=%0d prio=%0h want 1/3/20", bus.clic_irq_o, bus.clic_irq_id_o, bus.clic_irq_priority_o); end
    claim(3); step();
    total++; if ({bus.clic_irq_o, bus.clic_irq_id_o} !== {1'b1, 12'd9}) begin bad++; $display("FAIL tie_next: got irq=%0h id=%0d want 1/9", bus.clic_irq_o, bus.clic_irq_id_o); end
    claim(9); step();
    total++; if (bus.clic_irq_o !== 1'b0) begin bad++; $display("FAIL tie_done: got %0h want 0", bus.clic_irq_o); end
  endtask

  task automatic test_preempt();
    cfg_write(2, 1, 1, 'h10);
    cfg_write(7, 1, 1, 'h80);
    irq_src[2] = 1'b1;
    step(); irq_src[2] = 1'b0;
    step();
    total++; if ({bus.clic_irq_o, bus.clic_irq_id_o, bus.clic_irq_priority_o} !== {1'b1, 12'd2, 8'h10})
      begin bad++; $display("FAIL pre_low: got irq=%0h id=%0d prio=%0h want 1/2/10", bus.clic_irq_o, bus.clic_irq_id_o, bus.clic_irq_priority_o); end
    irq_src[7] = 1'b1;
    step(); irq_src[7] = 1'b0;
    total++; if ({bus.clic_irq_o, bus.clic_irq_id_o} !== {1'b1, 12'd2}) begin bad++; $display("FAIL pre_mid: got irq=%0h id=%0d want 1/2", bus.clic_irq_o, bus.clic_irq_id_o); end
    step();
    total++; if ({bus.clic_irq_o, bus.clic_irq_id_o, bus.clic_irq_priority_o} !== {1'b1, 12'd7, 8'h80})
      begin bad++; $display("FAIL pre_high: got irq=%0h id=%0d prio=%0h want 1/7/80", bus.clic_irq_o, bus.clic_irq_id_o, bus.clic_irq_priority_o); end
    claim(7); step();
    total++; if ({bus.clic_irq_o, bus.clic_irq_id_o} !== {1'b1, 12'd2}) begin bad++; $display("FAIL pre_back: got irq=%0h id=%0d want 1/2", bus.clic_irq_o, bus.clic_irq_id_o); end
    claim(2); step();
    total++; if (bus.clic_irq_o !== 1'b0) begin bad++; $display("FAIL pre_done: got %0h want 0", bus.clic_irq_o); end
  endtask

  task automatic test_level_threshold();
    cfg_write(4, 1, 0, 'h30);
    bus.threshold_i = 8'h30;
    irq_src[4] = 1'b1;
    repeat (3) step();
    total++; if ({pending[4], bus.clic_irq_o} !== 2'b10) begin bad++; $display("FAIL thr_block: got pend=%0h irq=%0h want 1/0", pending[4], bus.clic_irq_o); end
    bus.threshold_i = 8'h2F;
    step();
    total++; if ({bus.clic_irq_o, bus.clic_irq_id_o, bus.clic_irq_priority_o} !== {1'b1, 12'd4, 8'h30})
      begin bad++; $display("FAIL thr_pass: got irq=%0h id=%0d prio=%0h want 1/4/30", bus.clic_irq_o, bus.clic_irq_id_o, bus.clic_irq_priority_o); end
    irq_src[4] = 1'b0;
    step();
    total++; if (bus.clic_irq_o !== 1'b1) begin bad++; $display("FAIL lvl_drop1: got %0h want 1", bus.clic_irq_o); end
    step();
    total++; if (bus.clic_irq_o !== 1'b0) begin bad++; $display("FAIL lvl_drop2: got %0h want 0", bus.clic_irq_o); end
    bus.threshold_i = 8'h00;
  endtask

  task automatic test_set_claim_same();
    cfg_write(6, 1, 1, 'h50);
    irq_src[6] = 1'b1;
    step(); irq_src[6] = 1'b0;
    step();
    total++; if ({bus.clic_irq_o, bus.clic_irq_id_o} !== {1'b1, 12'd6}) begin bad++; $display("FAIL sc_req: got irq=%0h id=%0d want 1/6", bus.clic_irq_o, bus.clic_irq_id_o); end
    irq_src[6] = 1'b1;
    claim(6);
    irq_src[6] = 1'b0;
    total++; if (pending[6] !== 1'b1) begin bad++; $display("FAIL sc_pend: got %0h want 1", pending[6]); end
    repeat (2) step();
    total++; if ({bus.clic_irq_o, bus.clic_irq_id_o} !== {1'b1, 12'd6}) begin bad++; $display("FAIL sc_persist: got irq=%0h id=%0d want 1/6", bus.clic_irq_o, bus.clic_irq_id_o); end
    claim(6); step();
    total++; if (bus.clic_irq_o !== 1'b0) begin bad++; $display("FAIL sc_done: got %0h want 0", bus.clic_irq_o); end
  endtask

  task automatic test_disable();
    cfg_write(8, 1, 1, 'h60);
    irq_src[8] = 1'b1;
    step(); irq_src[8] = 1'b0;
    step();
    cfg_write(8, 0, 1, 'h60);
    step();
    total++; if ({bus.clic_irq_o, pending[8]} !== 2'b01) begin bad++; $display("FAIL dis_mask: got irq=%0h pend=%0h want 0/1", bus.clic_irq_o, pending[8]); end
    cfg_write(8, 1, 1, 'h60);
    step();
    total++; if ({bus.clic_irq_o, bus.clic_irq_id_o} !== {1'b1, 12'd8}) begin bad++; $display("FAIL dis_reen: got irq=%0h id=%0d want 1/8", bus.clic_irq_o, bus.clic_irq_id_o); end
    claim(8); step();
  endtask

  task automatic test_random();
    int plist [6] = '{0, 'h10, 'h20, 'h40, 'h80, 'hff};
    for (int i = 0; i < NUM_SRC; i++)
      cfg_write(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, plist[$urandom_range(0, 5)]);
    for (int c = 0; c < 400; c++) begin
      step();
      total++; if (bus.clic_irq_o !== m_irq) begin bad++; $display("FAIL rnd_irq c=%0d: got %0h want %0h", c, bus.clic_irq_o, m_irq); end
      total++; if (bus.clic_irq_id_o !== 12'(m_id)) begin bad++; $display("FAIL rnd_id c=%0d: got %0d want %0d", c, bus.clic_irq_id_o, m_id); end
      total++; if (bus.clic_irq_priority_o !== 8'(m_pr)) begin bad++; $display("FAIL rnd_prio c=%0d: got %0h want %0h", c, bus.clic_irq_priority_o, m_pr); end
      total++; if (pending !== model_pend()) begin bad++; $display("FAIL rnd_pend c=%0d: got %0h want %0h", c, pending, model_pend()); end
      irq_src ^= NUM_SRC'($urandom & $urandom & $urandom);
      bus.claim_i    = ($urandom_range(0, 2) == 0);
      bus.claim_id_i = ($urandom_range(0, 1) == 1) ? 12'(m_id) : 12'($urandom_range(0, 40));
      if ($urandom_range(0, 19) == 0)
        bus.threshold_i = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'h00;
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_idx   = IDX_W'($urandom_range(0, NUM_SRC - 1));
      cfg_wdata = 10'($urandom);
      if (c == 200) begin
        rst = 1'b1;
        #1;
        total++; if ({bus.clic_irq_o, bus.clic_irq_id_o, bus.clic_irq_priority_o, pending} !== '0)
          begin bad++; $display("FAIL mid_rst: got irq=%0h id=%0h prio=%0h pend=%0h want all 0", bus.clic_irq_o, bus.clic_irq_id_o, bus.clic_irq_priority_o, pending); end
        #2 rst = 1'b0;
      end
    end
    bus.claim_i = 1'b0;
    cfg_we      = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; irq_src = '1; cfg_we = 1'b0; cfg_idx = '0; cfg_wdata = '0;
    bus.claim_i = 1'b0; bus.claim_id_i = '0; bus.threshold_i = '0;
    test_reset();
    test_edge_claim();
    test_tie();
    test_preempt();
    test_level_threshold();
    test_set_claim_same();
    test_disable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
